hmac_verify_ctrl: RTL and testbench
===================================

HMAC_VERIFY_CTRL -- requirements
Module: hmac_verify_ctrl

Interface
REQ-001 SHALL have parameter BLK_CNT_W, default 8, giving the width of the message block count.
REQ-002 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to begin a verify job.
REQ-005 SHALL have port key, input, 384 bits: HMAC-384 key, sampled at start.
REQ-006 SHALL have port exp_tag, input, 384 bits: expected tag, sampled at start.
REQ-007 SHALL have port num_blocks, input, BLK_CNT_W bits: count of pre-padded 1024-bit blocks, sampled at start.
REQ-008 SHALL have port blk_valid, input, 1 bit: a block is offered.
REQ-009 SHALL have port blk_data, input, 1024 bits: the offered block.
REQ-010 SHALL have port blk_ready, output, 1 bit: the block is accepted when blk_valid and blk_ready are both high.
REQ-011 SHALL have port busy, output, 1 bit: a job is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port match, output, 1 bit: verify result, valid from done until the next start.
REQ-014 SHALL have port err, output, 1 bit: job rejected (num_blocks == 0), valid alongside done.
REQ-015 SHALL have port core_init, output, 1 bit: init command to the HMAC core.
REQ-016 SHALL have port core_next, output, 1 bit: next command to the HMAC core.
REQ-017 SHALL have port core_key, output, 384 bits: key driven to the HMAC core.
REQ-018 SHALL have port core_block, output, 1024 bits: block driven to the HMAC core.
REQ-019 SHALL have port core_ready, input, 1 bit: the HMAC core is idle.
REQ-020 SHALL have port core_tag_valid, input, 1 bit: the HMAC core tag is valid.
REQ-021 SHALL have port core_tag, input, 384 bits: tag from the HMAC core.

Function
REQ-022 SHALL implement states IDLE, GET_BLK, ISSUE, WAIT_TAG, CMP, DONE.
REQ-023 In IDLE, start SHALL latch key, exp_tag and num_blocks, clear match and err, load remaining = num_blocks and first = 1, and go to GET_BLK; if num_blocks == 0 it SHALL go to DONE with err = 1 instead.
REQ-024 blk_ready SHALL be high only in GET_BLK; on handshake, blk_data SHALL be latched into the block register and the FSM SHALL go to ISSUE.
REQ-025 ISSUE SHALL wait for core_ready == 1, then pulse core_init (if first) or core_next (otherwise) for exactly one cycle, clear first, decrement remaining, and go to WAIT_TAG.
REQ-026 core_init and core_next SHALL never be high together, and SHALL never be high outside ISSUE.
REQ-027 WAIT_TAG SHALL ignore core_tag_valid in the cycle immediately after the command pulse, then wait for core_tag_valid == 1 and core_ready == 1.
REQ-028 On leaving WAIT_TAG, the FSM SHALL go to GET_BLK if remaining != 0, else to CMP.
REQ-029 core_block and core_key SHALL hold the latched registers stable from ISSUE until WAIT_TAG exits.
REQ-030 CMP SHALL take exactly one cycle and register match = ~|(core_tag ^ exp_tag_reg), an OR-reduced XOR with no data-dependent early exit.
REQ-031 DONE SHALL pulse done for one cycle and then return to IDLE.
REQ-032 busy SHALL be high in every state except IDLE.
REQ-033 start asserted while busy SHALL be ignored.
REQ-034 Latency from the last core_tag_valid accepted in WAIT_TAG to done SHALL be 2 cycles.

Reset
REQ-035 Asserting reset_n SHALL force IDLE, with blk_ready, busy, done, match, err, core_init and core_next all 0, and all key, tag, block and count registers 0, including when asserted mid-job.

Configuration
REQ-036 With HMAC_VERIFY_ZEROIZE_EN defined, the key, exp_tag and block registers SHALL be cleared to 0 in the DONE cycle; without it, they SHALL retain their values until the next start.

Structure
REQ-037 The state encoding enum and the 384/1024 width constants SHALL live in the shared package hmac_verify_pkg.
REQ-038 The comparator SHALL be a sub-module, hmac_tag_cmp, comprising the 384-bit XOR-OR reduction and its result register.

Verification
REQ-039 Bench SHALL cover: num_blocks=1, correct exp_tag -> exactly one core_init pulse and no core_next, then done with match=1, err=0.
REQ-040 Bench SHALL cover: num_blocks=3 -> exactly one core_init and two core_next pulses, each following core_ready; done with match=1.
REQ-041 Bench SHALL cover: exp_tag differing from core_tag only in bit 0 -> match=0, with the same done latency as the match case.
REQ-042 Bench SHALL cover: num_blocks=0 -> done one cycle after start, err=1, match=0, no core command issued.
REQ-043 Bench SHALL cover: blk_valid held low for 10 cycles in GET_BLK, plus a second start while busy -> the FSM waits with no core command issued, and the second start is ignored.
REQ-044 Bench SHALL cover: reset_n asserted during WAIT_TAG -> all outputs 0 and state IDLE; a new job afterwards completes with match=1.

Source files
------------

// File: rtl/hmac_verify_pkg.sv
// Shared types and widths for the HMAC-384 tag verification controller.
package hmac_verify_pkg;

  localparam int unsigned KeyW = 384;
  localparam int unsigned TagW = 384;
  localparam int unsigned BlkW = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StGetBlk,
    StIssue,
    StWaitTag,
    StCmp,
    StDone
  } state_e;

endpackage

// File: rtl/hmac_tag_cmp.sv
// Constant-time tag comparator: full-width XOR-OR reduction into a result register.
module hmac_tag_cmp
  import hmac_verify_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            en,
  input  logic [TagW-1:0] tag,
  input  logic [TagW-1:0] exp_tag,
  output logic            match
);

  logic match_q;
  logic diff;

  // Every bit is always folded in, so timing never depends on where the tags differ.
  assign diff = |(tag ^ exp_tag);

  // Result register: cleared at job start, loaded once in the compare cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q <= 1'b0;
    end else if (clr) begin
      match_q <= 1'b0;
    end else if (en) begin
      match_q <= ~diff;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/hmac_verify_ctrl.sv
// HMAC-384 verify controller: feeds pre-padded blocks to an HMAC core, then compares
// the final tag against the expected tag.
// Define HMAC_VERIFY_ZEROIZE_EN to clear key, expected tag and block registers on done.
module hmac_verify_ctrl
  import hmac_verify_pkg::*;
#(
  parameter int unsigned BLK_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [KeyW-1:0]      key,
  input  logic [TagW-1:0]      exp_tag,
  input  logic [BLK_CNT_W-1:0] num_blocks,
  input  logic                 blk_valid,
  input  logic [BlkW-1:0]      blk_data,
  output logic                 blk_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic                 err,
  output logic                 core_init,
  output logic                 core_next,
  output logic [KeyW-1:0]      core_key,
  output logic [BlkW-1:0]      core_block,
  input  logic                 core_ready,
  input  logic                 core_tag_valid,
  input  logic [TagW-1:0]      core_tag
);

  state_e               state_q, state_d;
  logic [KeyW-1:0]      key_q, key_d;
  logic [TagW-1:0]      exp_tag_q, exp_tag_d;
  logic [BlkW-1:0]      blk_q, blk_d;
  logic [BLK_CNT_W-1:0] remaining_q, remaining_d;
  logic                 first_q, first_d;
  logic                 skip_q, skip_d;
  logic                 err_q, err_d;
  logic                 cmp_clr;
  logic                 cmp_en;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      key_q       <= '0;
      exp_tag_q   <= '0;
      blk_q       <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
      skip_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      exp_tag_q   <= exp_tag_d;
      blk_q       <= blk_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      skip_q      <= skip_d;
      err_q       <= err_d;
    end
  end

  // Next-state, register updates and core command pulses.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    exp_tag_d   = exp_tag_q;
    blk_d       = blk_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    skip_d      = skip_q;
    err_d       = err_q;
    core_init   = 1'b0;
    core_next   = 1'b0;
    cmp_clr     = 1'b0;
    cmp_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          key_d       = key;
          exp_tag_d   = exp_tag;
          remaining_d = num_blocks;
          first_d     = 1'b1;
          cmp_clr     = 1'b1;
          err_d       = (num_blocks == '0);
          state_d     = (num_blocks == '0) ? StDone : StGetBlk;
        end
      end
      StGetBlk: begin
        if (blk_valid) begin
          blk_d   = blk_data;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (core_ready) begin
          core_init   = first_q;
          core_next   = ~first_q;
          first_d     = 1'b0;
          remaining_d = remaining_q - 1'b1;
          skip_d      = 1'b1;
          state_d     = StWaitTag;
        end
      end
      StWaitTag: begin
        // The core may still show the previous tag right after a command; skip that cycle.
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (core_tag_valid && core_ready) begin
          state_d = (remaining_q != '0) ? StGetBlk : StCmp;
        end
      end
      StCmp: begin
        cmp_en  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
`ifdef HMAC_VERIFY_ZEROIZE_EN
        key_d     = '0;
        exp_tag_d = '0;
        blk_d     = '0;
`endif
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  hmac_tag_cmp u_tag_cmp (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cmp_clr),
    .en      (cmp_en),
    .tag     (core_tag),
    .exp_tag (exp_tag_q),
    .match   (match)
  );

  assign blk_ready  = (state_q == StGetBlk);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign err        = err_q;
  assign core_key   = key_q;
  assign core_block = blk_q;

endmodule

// File: tb/tb_hmac_verify_ctrl.sv
// Bench for hmac_verify_ctrl: job-level model plus a toy HMAC core driven on the falling edge.
module tb_hmac_verify_ctrl;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [383:0]  key = '0;
  logic [383:0]  exp_tag = '0;
  logic [7:0]    num_blocks = '0;
  logic          blk_valid = 1'b0;
  logic [1023:0] blk_data = '0;
  logic          blk_ready, busy, done, match, err, core_init, core_next;
  logic [383:0]  core_key;
  logic [1023:0] core_block;
  logic          core_ready = 1'b1;
  logic          core_tag_valid = 1'b0;
  logic [383:0]  core_tag = '0;

  hmac_verify_ctrl #(.BLK_CNT_W(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .key            (key),
    .exp_tag        (exp_tag),
    .num_blocks     (num_blocks),
    .blk_valid      (blk_valid),
    .blk_data       (blk_data),
    .blk_ready      (blk_ready),
    .busy           (busy),
    .done           (done),
    .match          (match),
    .err            (err),
    .core_init      (core_init),
    .core_next      (core_next),
    .core_key       (core_key),
    .core_block     (core_block),
    .core_ready     (core_ready),
    .core_tag_valid (core_tag_valid),
    .core_tag       (core_tag)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Job-level model state.
  logic          m_busy = 1'b0;
  logic [383:0]  m_key_vis = '0, m_exp = '0, m_acc = '0;
  int            m_nb = 0, m_acc_cnt = 0, m_cmds = 0, m_inits = 0, m_nexts = 0;
  logic [1023:0] m_blocks [4];
  logic          m_match_vis = 1'b0, m_err_vis = 1'b0;
  int            done_at = -1, start_cyc = 0, last_raise = 0;
  // Toy core state.
  logic          c_busy = 1'b0, c_last = 1'b0;
  int            c_t = 0, c_lat = 1, total_cmds = 0;
  logic [383:0]  c_acc = '0;
  // Results of the most recent completed job.
  logic          r_match = 1'b0, r_err = 1'b0;
  int            r_inits = 0, r_nexts = 0, r_lat = 0, r_start_lat = 0, jobs_done = 0;

  logic [1023:0] jb [4];

  // Toy keyed compression step; the same rule is used by the model and the fake core.
  function automatic logic [383:0] mac_step(input logic [383:0] acc, input logic [1023:0] b);
    logic [383:0] t;
    t = acc ^ b[383:0] ^ b[767:384] ^ {b[1023:768], 128'h0};
    return {t[382:0], t[383]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired, got no event, required event (cycle %0d)", name, cyc);
  endtask

  // Model, checker and toy core, all on the falling edge.
  always @(negedge clk) begin : model
    logic ci, cn, rdy, cbusy, was_busy, exp_done;
    cyc++;
    if (!reset_n) begin
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_match", 64'(match), 0);
      chk("rst_err", 64'(err), 0);
      chk("rst_blk_ready", 64'(blk_ready), 0);
      chk("rst_core_cmd", 64'({core_init, core_next}), 0);
      chk("rst_key_zero", 64'(core_key === '0), 1);
      chk("rst_block_zero", 64'(core_block === '0), 1);
      m_busy = 1'b0; m_key_vis = '0; m_match_vis = 1'b0; m_err_vis = 1'b0; done_at = -1;
      c_busy = 1'b0; core_ready = 1'b1; core_tag_valid = 1'b0; core_tag = '0;
    end else begin
      ci = core_init; cn = core_next; rdy = core_ready; cbusy = c_busy; was_busy = m_busy;
      exp_done = (cyc == done_at);
      if (exp_done) m_match_vis = (m_nb != 0) && (m_acc == m_exp);

      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(exp_done));
      chk("match", 64'(match), 64'(m_match_vis));
      chk("err", 64'(err), 64'(m_err_vis));
      chk("init_next_excl", 64'(ci & cn), 0);
      chk("blk_ready_only_busy", 64'(blk_ready & ~m_busy), 0);
      chk("cmd_with_blk_ready", 64'(blk_ready & (ci | cn)), 0);
      chk("core_key", 64'(core_key === m_key_vis), 1);
      if (cbusy) chk("core_block_stable", 64'(core_block === m_blocks[m_cmds-1]), 1);

      if (blk_valid && blk_ready) begin
        chk("blk_accept_room", 64'(m_acc_cnt < m_nb), 1);
        if (m_acc_cnt < 4) m_blocks[m_acc_cnt] = blk_data;
        m_acc = mac_step((m_acc_cnt == 0) ? m_key_vis : m_acc, blk_data);
        m_acc_cnt++;
      end

      if (exp_done) begin
        chk("job_inits", 64'(m_inits), (m_nb != 0) ? 64'd1 : 64'd0);
        chk("job_nexts", 64'(m_nexts), (m_nb > 1) ? 64'(m_nb - 1) : 64'd0);
        chk("job_blocks", 64'(m_acc_cnt), 64'(m_nb));
        r_match = match; r_err = err; r_inits = m_inits; r_nexts = m_nexts;
        r_lat = cyc - last_raise; r_start_lat = cyc - start_cyc;
        jobs_done++;
        m_busy = 1'b0;
`ifdef HMAC_VERIFY_ZEROIZE_EN
        m_key_vis = '0;
`endif
      end

      // Core: stale tag for one cycle after a command, then low, then the new tag.
      if (c_busy) begin
        c_t++;
        if (c_t == 2) begin
          core_ready = 1'b0; core_tag_valid = 1'b0;
        end else if (c_t == 2 + c_lat) begin
          core_ready = 1'b1; core_tag_valid = 1'b1; core_tag = c_acc;
          c_busy = 1'b0; last_raise = cyc;
          if (c_last) done_at = cyc + 2;
        end
      end

      if (ci | cn) begin
        chk("cmd_core_ready", 64'(rdy), 1);
        chk("cmd_core_idle", 64'(cbusy), 0);
        chk("cmd_in_job", 64'(was_busy), 1);
        chk("cmd_kind_init", 64'(ci), 64'(m_cmds == 0));
        chk("cmd_has_block", 64'(m_cmds < m_acc_cnt), 1);
        if (m_cmds < 4) chk("cmd_block", 64'(core_block === m_blocks[m_cmds]), 1);
        c_acc = mac_step(ci ? core_key : c_acc, core_block);
        m_cmds++;
        if (ci) m_inits++; else m_nexts++;
        total_cmds++;
        c_lat = 1 + (total_cmds % 3);
        c_busy = 1'b1; c_t = 0; c_last = (m_cmds == m_nb);
      end

      if (start && !was_busy) begin
        m_busy = 1'b1; m_key_vis = key; m_exp = exp_tag; m_nb = int'(num_blocks);
        m_acc_cnt = 0; m_cmds = 0; m_inits = 0; m_nexts = 0;
        m_match_vis = 1'b0; m_err_vis = (num_blocks == '0); start_cyc = cyc;
        if (num_blocks == '0) done_at = cyc + 1;
      end
    end
  end

  task automatic do_start(input logic [383:0] k, input logic [383:0] e, input int n);
    @(posedge clk); #2;
    key = k; exp_tag = e; num_blocks = 8'(n); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic offer(input logic [1023:0] b);
    int n = 0;
    logic acc = 1'b0;
    blk_data = b; blk_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk); n++;
      if (blk_ready) acc = 1'b1;
    end
    if (!acc) bound_fail("blk_handshake");
    @(posedge clk); #2;
    blk_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk); n++;
      if (done) seen = 1'b1;
    end
    if (!seen) bound_fail("done_wait");
    @(posedge clk); #2;
  endtask

  task automatic run_job(input logic [383:0] k, input logic [383:0] e, input int n,
                         input logic stall);
    do_start(k, e, n);
    if (stall) begin
      repeat (3) @(posedge clk); #2;
      key = ~k; num_blocks = '0; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (7) @(posedge clk); #2;
      chk("stall_no_cmd", 64'(m_cmds), 0);
      chk("stall_still_busy", 64'(busy), 1);
    end
    for (int i = 0; i < n; i++) offer(jb[i]);
    wait_done();
  endtask

  initial begin : stim
    logic [383:0] kc, ec;
    int jd, n;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
    chk("idle_after_reset", 64'(busy), 0);

    // Single block, key=1, block=0: tag = rotl(1,1) = 2.
    jb[0] = '0;
    run_job(384'd1, 384'd2, 1, 1'b0);
    chk("one_blk_match", 64'(r_match), 1);
    chk("one_blk_err", 64'(r_err), 0);
    chk("one_blk_inits", 64'(r_inits), 1);
    chk("one_blk_nexts", 64'(r_nexts), 0);
    chk("one_blk_latency", 64'(r_lat), 2);

    // Expected tag off by bit 0 only.
    run_job(384'd1, 384'd3, 1, 1'b0);
    chk("bit0_mismatch", 64'(r_match), 0);
    chk("bit0_latency", 64'(r_lat), 2);

    // Three blocks.
    kc = {12{32'h1357_9BDF}};
    jb[0] = {32{32'hA5A5_0001}};
    jb[1] = {16{64'h0F0F_1234_5678_9ABC}};
    jb[2] = {32{32'hFFFF_FFFF}} ^ {992'h0, 32'hDEAD_BEEF};
    ec = mac_step(mac_step(mac_step(kc, jb[0]), jb[1]), jb[2]);
    run_job(kc, ec, 3, 1'b0);
    chk("three_blk_match", 64'(r_match), 1);
    chk("three_blk_inits", 64'(r_inits), 1);
    chk("three_blk_nexts", 64'(r_nexts), 2);

    // Zero blocks: rejected.
    do_start(kc, ec, 0);
    wait_done();
    chk("zero_err", 64'(r_err), 1);
    chk("zero_match", 64'(r_match), 0);
    chk("zero_start_to_done", 64'(r_start_lat), 1);
    chk("zero_no_cmd", 64'(r_inits + r_nexts), 0);

    // Stalled source plus a start while busy.
    jd = jobs_done;
    ec = mac_step(mac_step(kc, jb[0]), jb[1]);
    run_job(kc, ec, 2, 1'b1);
    chk("stall_one_job", 64'(jobs_done - jd), 1);
    chk("stall_match", 64'(r_match), 1);
    chk("stall_nexts", 64'(r_nexts), 1);

    // Reset while waiting for the tag.
    do_start(kc, ec, 2);
    offer(jb[0]);
    n = 0;
    while (m_cmds < 1 && n < 100) begin
      @(negedge clk); n++;
    end
    if (m_cmds < 1) bound_fail("cmd_before_reset");
    @(posedge clk); #2;
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b1;
    chk("post_reset_idle", 64'(busy), 0);
    jb[0] = '0;
    run_job(384'd1, 384'd2, 1, 1'b0);
    chk("post_reset_match", 64'(r_match), 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
